// File: rtl/tile_pingpong_buffer_pkg.sv
// tile_pingpong_buffer_pkg: shared defaults, bank indices and depth helper for the ping-pong tile buffer
package tile_pingpong_buffer_pkg;
    localparam int N_DEF = 8;
    localparam int M_DEF = 4;
    typedef logic bank_t;
    localparam bank_t BANK0 = 1'b0;
    localparam bank_t BANK1 = 1'b1;
    function automatic int depth(input int m);
        return 1 << m;
    endfunction
endpackage

// File: rtl/tile_pingpong_buffer_bank_mem.sv
// tile_pingpong_buffer_bank_mem: one tile bank, single write port and registered read port, no reset
module tile_pingpong_buffer_bank_mem
    import tile_pingpong_buffer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         we,
    input  logic [M-1:0] wadr,
    input  logic [N-1:0] wdata,
    input  logic         re,
    input  logic [M-1:0] radr,
    output logic [N-1:0] rdata
);
    logic [N-1:0] mem [depth(M)];
    // rdata only moves on an accepted read so it holds across idle cycles
    always_ff @(posedge clk) begin
        if (we) mem[wadr] <= wdata;
        if (re) rdata <= mem[radr];
    end
endmodule

// File: rtl/tile_pingpong_buffer.sv
// tile_pingpong_buffer: double-banked tile buffer; loader fills one bank while the reader consumes the other
// rel is the reader's release strobe (release is a reserved word)
module tile_pingpong_buffer
    import tile_pingpong_buffer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic [N-1:0] datain,
    input  logic         commit,
    output logic         wr_ready,
    output logic         wr_full,
    output logic [M:0]   wr_count,
    input  logic         rd,
    input  logic [M-1:0] adr,
    input  logic         rel,
    output logic         rd_ready,
    output logic [M:0]   rd_len,
    output logic [N-1:0] dataout,
    output logic         rd_valid
);
    localparam logic [M:0] DEPTH = (M+1)'(depth(M));
    bank_t wbank, rbank, sel;
    logic [1:0] committed;
    logic [M:0] len [2];
    logic [M:0] top, top_nxt;
    logic hit;
    logic [N-1:0] rdata [2];
    logic wr_acc, cm_eff, rd_acc, rl_eff;
    assign wr_ready = !committed[wbank];
    assign rd_ready = committed[rbank];
    assign wr_full  = top == DEPTH;
    assign wr_count = top;
    assign rd_len   = len[rbank];
    assign wr_acc   = wr && wr_ready && !wr_full;
    assign top_nxt  = top + {{M{1'b0}}, wr_acc};
    assign cm_eff   = commit && wr_ready && top_nxt != '0;
    assign rd_acc   = rd && rd_ready;
    assign rl_eff   = rel && rd_ready;
    // out-of-range reads and the reset state both present zero instead of bank contents
    assign dataout  = hit ? (sel == BANK1 ? rdata[1] : rdata[0]) : '0;
    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_pingpong_buffer_bank_mem #(.N(N), .M(M)) u_mem (
            .clk  (clk),
            .we   (wr_acc && wbank == bank_t'(b)),
            .wadr (top[M-1:0]),
            .wdata(datain),
            .re   (rd_acc && rbank == bank_t'(b)),
            .radr (adr),
            .rdata(rdata[b])
        );
    end
    // bank pointers, fill level, tile lengths and read-side flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank     <= BANK0;
            rbank     <= BANK0;
            sel       <= BANK0;
            top       <= '0;
            committed <= '0;
            len[0]    <= '0;
            len[1]    <= '0;
            hit       <= 1'b0;
            rd_valid  <= 1'b0;
        end else if (clr) begin
            wbank     <= BANK0;
            rbank     <= BANK0;
            sel       <= BANK0;
            top       <= '0;
            committed <= '0;
            len[0]    <= '0;
            len[1]    <= '0;
            hit       <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            top      <= cm_eff ? '0 : top_nxt;
            wbank    <= cm_eff ? ~wbank : wbank;
            rbank    <= rl_eff ? ~rbank : rbank;
            rd_valid <= rd_acc;
            sel      <= rd_acc ? rbank : sel;
            hit      <= rd_acc ? {1'b0, adr} < len[rbank] : hit;
            for (int b = 0; b < 2; b++) begin
                committed[b] <= (cm_eff && wbank == bank_t'(b)) ? 1'b1 :
                                (rl_eff && rbank == bank_t'(b)) ? 1'b0 : committed[b];
                len[b]       <= (cm_eff && wbank == bank_t'(b)) ? top_nxt : len[b];
            end
        end
    end
endmodule
